speed_gauge: RTL and testbench

Parametrised speed accumulator with a sequential binary-to-BCD converter. It ramps a speed value up while the car is driven, decays it when idle, and decays it faster under brake, saturating at both ends. The value is converted to DIGITS packed BCD digits using an iterative shift-add-3 engine with a busy/valid status. It sits between the motor-drive decode and the seven-segment display mux, and replaces the fixed 3-digit combinational speed counter.

---
 rtl/speed_gauge.sv | 181 ++++++++++++++++++
 tb/tb_speed_gauge.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/speed_gauge.sv
// speed_gauge: saturating speed accumulator feeding an iterative shift-add-3 binary-to-BCD converter.
// Optional leading-zero blanking of the BCD output is enabled by defining SPEED_GAUGE_LEADZ_EN.
module speed_gauge #(
    parameter int WIDTH      = 9,
    parameter int MAX_VAL    = 340,
    parameter int DIGITS     = 3,
    parameter int ACC_STEP   = 1,
    parameter int DEC_STEP   = 1,
    parameter int BRAKE_STEP = 4,
    parameter int TICK_DIV   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            drive,
    input  logic                  brake,
    output logic [WIDTH-1:0]      value,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic                  at_max,
    output logic                  at_zero
);
    localparam int BW = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [WIDTH:0]   MAX_EXT    = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   STEP_ACC   = (WIDTH + 1)'(ACC_STEP);
    localparam logic [WIDTH:0]   STEP_DEC   = (WIDTH + 1)'(DEC_STEP);
    localparam logic [WIDTH:0]   STEP_BRK   = (WIDTH + 1)'(BRAKE_STEP);
    localparam logic [CW-1:0]    CNT_LOAD   = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST   = CW'(1);

`ifdef SPEED_GAUGE_LEADZ_EN
    function automatic logic [BW-1:0] blank_lead(input logic [BW-1:0] raw);
        logic [BW-1:0] res;
        logic          lead;
        res  = raw;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (raw[4*i +: 4] == 4'h0)) begin
                res[4*i +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return res;
    endfunction
    localparam logic [BW-1:0] BCD_RST = blank_lead('0);
`else
    localparam logic [BW-1:0] BCD_RST = '0;
`endif

    // ---------------- update-tick prescaler ----------------
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    // ---------------- speed accumulator ----------------
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH:0]   value_ext, sum_ext;
    logic             driving;

    assign driving   = drive[0] ^ drive[1];
    assign value_ext = {1'b0, value_q};
    assign sum_ext   = value_ext + STEP_ACC;

    // Compare before subtracting so the result can never wrap below zero.
    always_comb begin
        value_d = value_q;
        if (tick) begin
            if (brake) begin
                value_d = (value_ext < STEP_BRK) ? '0 : WIDTH'(value_ext - STEP_BRK);
            end else if (driving) begin
                value_d = (sum_ext >= MAX_EXT) ? MAX_W : sum_ext[WIDTH-1:0];
            end else begin
                value_d = (value_ext < STEP_DEC) ? '0 : WIDTH'(value_ext - STEP_DEC);
            end
        end
    end

    // ---------------- BCD converter ----------------
    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    snap_q, snap_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic [WIDTH-1:0]    last_conv_q, last_conv_d;
    logic [BW-1:0]       scratch_q, scratch_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [BW-1:0]       scratch_adj;
    logic [BW-1:0]       bcd_fmt;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW+WIDTH-1:0] shifted;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_add3
            assign scratch_adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ?
                                            scratch_q[4*gi +: 4] + 4'd3 :
                                            scratch_q[4*gi +: 4];
        end
    endgenerate

    assign shifted = {scratch_adj, shreg_q} << 1;

`ifdef SPEED_GAUGE_LEADZ_EN
    assign bcd_fmt = blank_lead(shifted[BW+WIDTH-1:WIDTH]);
`else
    assign bcd_fmt = shifted[BW+WIDTH-1:WIDTH];
`endif

    // snap_q keeps the unshifted value so last_conv can be set when the result lands.
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        shreg_d     = shreg_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        last_conv_d = last_conv_q;
        case (state_q)
            S_IDLE: begin
                if (value_q != last_conv_q) begin
                    snap_d    = value_q;
                    shreg_d   = value_q;
                    scratch_d = '0;
                    cnt_d     = CNT_LOAD;
                    state_d   = S_CONV;
                end
            end
            S_CONV: begin
                scratch_d = shifted[BW+WIDTH-1:WIDTH];
                shreg_d   = shifted[WIDTH-1:0];
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CNT_LAST) begin
                    bcd_d       = bcd_fmt;
                    last_conv_d = snap_q;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            value_q     <= '0;
            state_q     <= S_IDLE;
            snap_q      <= '0;
            shreg_q     <= '0;
            last_conv_q <= '0;
            scratch_q   <= '0;
            bcd_q       <= BCD_RST;
            cnt_q       <= '0;
        end else begin
            presc_q     <= presc_d;
            value_q     <= value_d;
            state_q     <= state_d;
            snap_q      <= snap_d;
            shreg_q     <= shreg_d;
            last_conv_q <= last_conv_d;
            scratch_q   <= scratch_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
        end
    end

    assign value     = value_q;
    assign bcd       = bcd_q;
    assign busy      = (state_q == S_CONV);
    assign bcd_valid = (value_q == last_conv_q) && !busy;
    assign at_max    = (value_q == MAX_W);
    assign at_zero   = (value_q == '0);

endmodule

// File: tb/tb_speed_gauge.sv
// Directed self-checking bench for speed_gauge: default instance plus a TICK_DIV=4 instance.
module tb_speed_gauge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  drive = 2'b00;
    logic [1:0]  drive4 = 2'b00;
    logic        brake = 1'b0;
    logic        brake4 = 1'b0;

    logic [8:0]  value, value4;
    logic [11:0] bcd, bcd4;
    logic        bcd_valid, busy, at_max, at_zero;
    logic        bcd_valid4, busy4, at_max4, at_zero4;

    int checks = 0;
    int errors = 0;

`ifdef SPEED_GAUGE_LEADZ_EN
    localparam logic [11:0] B000 = 12'hFF0;
    localparam logic [11:0] B001 = 12'hFF1;
`else
    localparam logic [11:0] B000 = 12'h000;
    localparam logic [11:0] B001 = 12'h001;
`endif
    localparam logic [11:0] B340 = 12'h340;

    always #5 clk = ~clk;

    speed_gauge dut (
        .clk(clk), .rst_n(rst_n), .drive(drive), .brake(brake),
        .value(value), .bcd(bcd), .bcd_valid(bcd_valid), .busy(busy),
        .at_max(at_max), .at_zero(at_zero)
    );

    speed_gauge #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .drive(drive4), .brake(brake4),
        .value(value4), .bcd(bcd4), .bcd_valid(bcd_valid4), .busy(busy4),
        .at_max(at_max4), .at_zero(at_zero4)
    );

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++; if (value !== 9'd0) begin errors++; $display("FAIL reset_value got %0d want 0", value); end
        checks++; if (bcd !== B000) begin errors++; $display("FAIL reset_bcd got %h want %h", bcd, B000); end
        checks++; if (bcd_valid !== 1'b1) begin errors++; $display("FAIL reset_valid got %b want 1", bcd_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (at_zero !== 1'b1 || at_max !== 1'b0) begin errors++; $display("FAIL reset_flags got zero=%b max=%b want 1 0", at_zero, at_max); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("test_reset done checks=%0d errors=%0d", checks, errors);
    endtask

    // value 0 -> 1 -> 0: first conversion snapshots 1, second converges to 0
    task automatic test_back_to_back;
        drive = 2'b01;
        clk_n(1);
        checks++; if (value !== 9'd1) begin errors++; $display("FAIL b2b_value1 got %0d want 1", value); end
        checks++; if (bcd_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got %b want 0", bcd_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_e1 got %b want 0", busy); end
        drive = 2'b11;
        clk_n(1);
        checks++; if (value !== 9'd0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_e2 got value=%0d busy=%b want 0 1", value, busy); end
        clk_n(8);
        checks++; if (bcd !== B000 || busy !== 1'b1) begin errors++; $display("FAIL b2b_e10 got bcd=%h busy=%b want %h 1", bcd, busy, B000); end
        clk_n(1);
        checks++; if (bcd !== B001) begin errors++; $display("FAIL b2b_first_bcd got %h want %h", bcd, B001); end
        checks++; if (busy !== 1'b0 || bcd_valid !== 1'b0) begin errors++; $display("FAIL b2b_e11 got busy=%b valid=%b want 0 0", busy, bcd_valid); end
        clk_n(9);
        checks++; if (bcd !== B001 || bcd_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_e20 got bcd=%h valid=%b busy=%b want %h 0 1", bcd, bcd_valid, busy, B001); end
        clk_n(1);
        checks++; if (bcd !== B000 || bcd_valid !== 1'b1) begin errors++; $display("FAIL b2b_final got bcd=%h valid=%b want %h 1", bcd, bcd_valid, B000); end
        $display("test_back_to_back done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_accel_decay;
        drive = 2'b01;
        clk_n(5);
        checks++; if (value !== 9'd5 || at_zero !== 1'b0) begin errors++; $display("FAIL accel_value got %0d zero=%b want 5 0", value, at_zero); end
        checks++; if (busy !== 1'b1 || bcd_valid !== 1'b0) begin errors++; $display("FAIL accel_busy got busy=%b valid=%b want 1 0", busy, bcd_valid); end
        drive = 2'b00;
        clk_n(3);
        checks++; if (value !== 9'd2) begin errors++; $display("FAIL decay_value got %0d want 2", value); end
        clk_n(2);
        checks++; if (value !== 9'd0 || at_zero !== 1'b1) begin errors++; $display("FAIL decay_zero got %0d zero=%b want 0 1", value, at_zero); end
        for (int i = 0; i < 40 && bcd_valid !== 1'b1; i++) clk_n(1);
        checks++; if (bcd_valid !== 1'b1) begin errors++; $display("FAIL decay_settle_timeout got valid=%b want 1", bcd_valid); end
        checks++; if (bcd !== B000) begin errors++; $display("FAIL decay_bcd got %h want %h", bcd, B000); end
        $display("test_accel_decay done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_brake;
        drive = 2'b01;
        clk_n(6);
        checks++; if (value !== 9'd6) begin errors++; $display("FAIL brake_pre got %0d want 6", value); end
        brake = 1'b1;
        clk_n(1);
        checks++; if (value !== 9'd2) begin errors++; $display("FAIL brake_step1 got %0d want 2", value); end
        clk_n(1);
        checks++; if (value !== 9'd0 || at_zero !== 1'b1) begin errors++; $display("FAIL brake_step2 got %0d zero=%b want 0 1", value, at_zero); end
        clk_n(1);
        checks++; if (value !== 9'd0) begin errors++; $display("FAIL brake_nowrap got %0d want 0", value); end
        for (int i = 0; i < 40 && bcd_valid !== 1'b1; i++) clk_n(1);
        checks++; if (bcd_valid !== 1'b1 || bcd !== B000) begin errors++; $display("FAIL brake_bcd got bcd=%h valid=%b want %h 1", bcd, bcd_valid, B000); end
        brake = 1'b0;
        drive = 2'b00;
        $display("test_brake done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_saturation;
        drive = 2'b10;
        clk_n(339);
        checks++; if (value !== 9'd339 || at_max !== 1'b0) begin errors++; $display("FAIL sat_339 got %0d max=%b want 339 0", value, at_max); end
        clk_n(1);
        checks++; if (value !== 9'd340 || at_max !== 1'b1) begin errors++; $display("FAIL sat_340 got %0d max=%b want 340 1", value, at_max); end
        clk_n(60);
        checks++; if (value !== 9'd340) begin errors++; $display("FAIL sat_hold got %0d want 340", value); end
        checks++; if (bcd !== B340 || bcd_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL sat_bcd got bcd=%h valid=%b busy=%b want %h 1 0", bcd, bcd_valid, busy, B340); end
        $display("test_saturation done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_tick_div;
        rst_n = 1'b0;
        #3;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive4 = 2'b01;
        drive = 2'b00;
        clk_n(3);
        checks++; if (value4 !== 9'd0) begin errors++; $display("FAIL div_before_tick got %0d want 0", value4); end
        clk_n(1);
        checks++; if (value4 !== 9'd1) begin errors++; $display("FAIL div_first_tick got %0d want 1", value4); end
        clk_n(12);
        checks++; if (value4 !== 9'd4) begin errors++; $display("FAIL div_16clk got %0d want 4", value4); end
        drive4 = 2'b00;
        $display("test_tick_div done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_mid_conv;
        drive = 2'b10;
        clk_n(20);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got %b want 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || value !== 9'd0) begin errors++; $display("FAIL midrst_async got busy=%b value=%0d want 0 0", busy, value); end
        checks++; if (bcd !== B000 || bcd_valid !== 1'b1) begin errors++; $display("FAIL midrst_bcd got bcd=%h valid=%b want %h 1", bcd, bcd_valid, B000); end
        drive = 2'b00;
        clk_n(2);
        rst_n = 1'b1;
        clk_n(15);
        checks++; if (bcd !== B000 || bcd_valid !== 1'b1 || value !== 9'd0) begin errors++; $display("FAIL midrst_after got bcd=%h valid=%b value=%0d want %h 1 0", bcd, bcd_valid, value, B000); end
        $display("test_reset_mid_conv done checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_accel_decay;
        test_brake;
        test_saturation;
        test_tick_div;
        test_reset_mid_conv;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
